ucsbece154a_fetch: RTL and testbench

- Instruction fetch stage directly upstream of the controller and datapath.
- Holds the fetch PC and issues word requests to an instruction memory with variable latency and in-order responses.
- Buffers returned instructions in a small FIFO and presents the head instruction, its PC and its decode fields (op, funct3, funct7b5) to the controller.
- Consumes the controller's taken-branch/jump decision as a redirect that flushes all in-flight work.

---
 rtl/ucsbece154a_fetch_pkg.sv | 22 ++
 rtl/ucsbece154a_ibuf.sv | 51 +++++
 rtl/ucsbece154a_fetch.sv | 124 ++++++++++++
 tb/tb_ucsbece154a_fetch.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucsbece154a_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
// Field positions match the RV32I base encoding consumed by the controller.
package ucsbece154a_fetch_pkg;

  localparam int OP_LSB   = 0;
  localparam int OP_MSB   = 6;
  localparam int F3_LSB   = 12;
  localparam int F3_MSB   = 14;
  localparam int F7B5_BIT = 30;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ucsbece154a_ibuf.sv
// Small synchronous FIFO with flush; DEPTH must be a power of two so the
// pointers wrap naturally.
module ucsbece154a_ibuf #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is data-only; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (!reset && !flush && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ucsbece154a_fetch.sv
// Instruction fetch stage: issues word requests to a variable-latency,
// in-order instruction memory and buffers responses for the controller.
module ucsbece154a_fetch
  import ucsbece154a_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pcplus4_o,
  output logic [6:0]  op_o,
  output logic [2:0]  funct3_o,
  output logic        funct7b5_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_target_i
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]  fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] count;
  logic [CW-1:0] tag_count;
  logic          buf_full;
  logic          buf_empty;
  logic          tag_full;
  logic          tag_empty;
  logic [31:0]   tag_head;
  fetch_entry_t  buf_head;
  fetch_entry_t  buf_push_data;
  fetch_entry_t  last_head;
  logic          pop;
  logic          push;
  logic          grant;
  logic [31:0]   inflight;
  logic          unused_status;

  assign pop      = instr_valid_o & instr_ready_i;
  assign push     = imem_rvalid_i & (drop == '0) & ~redirect_i;
  assign inflight = 32'(count) + 32'(outstanding) - 32'(pop);

  assign imem_req_o  = ~reset & ~redirect_i & (inflight < 32'(DEPTH));
  assign imem_addr_o = fetch_pc;
  assign grant       = imem_req_o & imem_gnt_i;

  assign buf_push_data = '{pc: tag_head, instr: imem_rdata_i};
  assign unused_status = ^{tag_count, tag_full, tag_empty, buf_full};

  // PC of every granted request, popped as its response is accepted.
  ucsbece154a_ibuf #(.WIDTH(32), .DEPTH(DEPTH)) u_tag (
    .clk       (clk),
    .reset     (reset),
    .push      (grant),
    .push_data (fetch_pc),
    .pop       (push),
    .flush     (redirect_i),
    .head      (tag_head),
    .count     (tag_count),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  ucsbece154a_ibuf #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (buf_push_data),
    .pop       (pop),
    .flush     (redirect_i),
    .head      (buf_head),
    .count     (count),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  assign instr_valid_o = ~buf_empty;
  assign instr_o       = instr_valid_o ? buf_head.instr : last_head.instr;
  assign pc_o          = instr_valid_o ? buf_head.pc    : last_head.pc;
  assign pcplus4_o     = pc_o + 32'd4;
  assign op_o          = instr_o[OP_MSB:OP_LSB];
  assign funct3_o      = instr_o[F3_MSB:F3_LSB];
  assign funct7b5_o    = instr_o[F7B5_BIT];

  // On redirect, responses still in flight are counted into drop so they
  // are discarded when they eventually arrive.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      last_head   <= '0;
    end else begin
      if (instr_valid_o) last_head <= buf_head;
      if (redirect_i)
        fetch_pc <= word_align(redirect_target_i);
      else if (grant)
        fetch_pc <= fetch_pc + 32'd4;
      outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid_i);
      if (redirect_i)
        drop <= outstanding - CW'(imem_rvalid_i);
      else if (imem_rvalid_i && drop != '0)
        drop <= drop - 1'b1;
    end
  end

`ifdef SIM
  always_ff @(posedge clk) begin
    if (!reset && imem_rvalid_i && outstanding == '0)
      $error("ucsbece154a_fetch: rvalid with no outstanding request");
  end
`endif

endmodule

// File: tb/tb_ucsbece154a_fetch.sv
// Self-checking bench for ucsbece154a_fetch: randomized in-order memory and
// a queue-based reference model of the fetch stream.
module tb_ucsbece154a_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pcplus4_o;
  logic [6:0]  op_o;
  logic [2:0]  funct3_o;
  logic        funct7b5_o;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_target_i = '0;

  ucsbece154a_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .imem_req_o        (imem_req_o),
    .imem_addr_o       (imem_addr_o),
    .imem_gnt_i        (imem_gnt_i),
    .imem_rvalid_i     (imem_rvalid_i),
    .imem_rdata_i      (imem_rdata_i),
    .instr_valid_o     (instr_valid_o),
    .instr_ready_i     (instr_ready_i),
    .instr_o           (instr_o),
    .pc_o              (pc_o),
    .pcplus4_o         (pcplus4_o),
    .op_o              (op_o),
    .funct3_o          (funct3_o),
    .funct7b5_o        (funct7b5_o),
    .redirect_i        (redirect_i),
    .redirect_target_i (redirect_target_i)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } entry_t;

  // Memory environment: requests as the DUT actually issued them.
  mreq_t       memq[$];
  // Reference model: expected outstanding PCs, buffered entries, drop count.
  logic [31:0] minfl[$];
  entry_t      mbuf[$];
  int          mdrop;
  logic [31:0] mpc;
  entry_t      last_e;
  bit          model_known;

  int tests_run = 0;
  int fails = 0;
  int cyc = 0;

  bit          reset_drv = 1'b1;
  bit          ready_drv = 1'b0;
  bit          redirect_drv = 1'b0;
  logic [31:0] target_drv = '0;
  int          gnt_pct = 100;
  int          lat_min = 1;
  int          lat_max = 1;

  logic [31:0] issued_addr[$];
  int          issued_cyc[$];
  logic [31:0] popped_pc[$];
  int          pops = 0;
  int          grants = 0;
  int          first_valid_cyc = -1;
  int          release_cyc = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h0000_0013;
  endfunction

  // One clock cycle: drive at negedge, check after settling, update model.
  task automatic step();
    bit          exp_req;
    bit          pop_m;
    bit          rv;
    bit          g;
    entry_t      e;
    entry_t      ne;
    logic [31:0] rpc;
    @(negedge clk);
    reset             = reset_drv;
    instr_ready_i     = ready_drv;
    redirect_i        = redirect_drv;
    redirect_target_i = target_drv;
    rv = (memq.size() > 0) && (memq[0].due <= cyc);
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? mem_word(memq[0].addr) : $urandom;
    #1;
    pop_m   = model_known && (mbuf.size() > 0) && ready_drv;
    exp_req = !reset_drv && !redirect_drv &&
              ((mbuf.size() + minfl.size() - int'(pop_m)) < DEPTH);

    tests_run++;
    if (imem_req_o !== exp_req) begin
      fails++;
      $display("[TB] FAIL req cyc=%0d got=%b exp=%b", cyc, imem_req_o, exp_req);
    end
    if (exp_req) begin
      tests_run++;
      if (imem_addr_o !== mpc) begin
        fails++;
        $display("[TB] FAIL addr cyc=%0d got=%h exp=%h", cyc, imem_addr_o, mpc);
      end
    end
    if (model_known) begin
      if (mbuf.size() > 0) e = mbuf[0];
      else e = last_e;
      tests_run++;
      if (instr_valid_o !== (mbuf.size() > 0)) begin
        fails++;
        $display("[TB] FAIL valid cyc=%0d got=%b exp=%b", cyc, instr_valid_o, mbuf.size() > 0);
      end
      tests_run++;
      if (instr_o !== e.instr || pc_o !== e.pc || pcplus4_o !== e.pc + 32'd4) begin
        fails++;
        $display("[TB] FAIL head cyc=%0d got instr=%h pc=%h pc4=%h exp instr=%h pc=%h pc4=%h",
                 cyc, instr_o, pc_o, pcplus4_o, e.instr, e.pc, e.pc + 32'd4);
      end
      tests_run++;
      if (op_o !== e.instr[6:0] || funct3_o !== e.instr[14:12] || funct7b5_o !== e.instr[30]) begin
        fails++;
        $display("[TB] FAIL decode cyc=%0d got op=%h f3=%h f7b5=%b exp op=%h f3=%h f7b5=%b",
                 cyc, op_o, funct3_o, funct7b5_o, e.instr[6:0], e.instr[14:12], e.instr[30]);
      end
    end

    g = ($urandom_range(0, 99) < gnt_pct);
    imem_gnt_i = g;

    if (!reset_drv && instr_valid_o === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (!reset_drv && instr_valid_o === 1'b1 && ready_drv) begin
      popped_pc.push_back(pc_o);
      pops++;
    end
    if (rv) void'(memq.pop_front());
    if (!reset_drv && imem_req_o === 1'b1 && g) begin
      issued_addr.push_back(imem_addr_o);
      issued_cyc.push_back(cyc);
      grants++;
      memq.push_back('{imem_addr_o, cyc + $urandom_range(lat_min, lat_max)});
    end

    if (reset_drv) begin
      memq.delete();
      minfl.delete();
      mbuf.delete();
      mdrop       = 0;
      mpc         = RESET_PC;
      last_e      = '{32'h0, 32'h0};
      model_known = 1'b1;
    end else begin
      rpc = '0;
      if (rv && minfl.size() > 0) rpc = minfl.pop_front();
      if (mbuf.size() > 0) last_e = mbuf[0];
      if (redirect_drv) begin
        mbuf.delete();
        mdrop = minfl.size();
        mpc   = {target_drv[31:2], 2'b00};
      end else begin
        if (pop_m) void'(mbuf.pop_front());
        if (rv) begin
          if (mdrop > 0) mdrop--;
          else begin
            ne.pc    = rpc;
            ne.instr = mem_word(rpc);
            mbuf.push_back(ne);
          end
        end
        if (exp_req && g) begin
          minfl.push_back(mpc);
          mpc = mpc + 32'd4;
        end
      end
    end
    cyc++;
  endtask

  task automatic do_reset(input int n);
    reset_drv    = 1'b1;
    redirect_drv = 1'b0;
    ready_drv    = 1'b1;
    for (int i = 0; i < n; i++) step();
    reset_drv = 1'b0;
    issued_addr.delete();
    issued_cyc.delete();
    popped_pc.delete();
    first_valid_cyc = -1;
    release_cyc     = cyc;
  endtask

  task automatic test_reset();
    do_reset(3);
    tests_run++;
    if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_ctrl got valid=%b req=%b exp 0 0", instr_valid_o, imem_req_o);
    end
    tests_run++;
    if (instr_o !== 32'h0 || pc_o !== 32'h0 || pcplus4_o !== 32'h4) begin
      fails++;
      $display("[TB] FAIL reset_head got instr=%h pc=%h pc4=%h exp 0 0 4", instr_o, pc_o, pcplus4_o);
    end
  endtask

  task automatic test_sequential();
    int p0;
    lat_min = 1; lat_max = 1; gnt_pct = 100;
    do_reset(2);
    for (int i = 0; i < 12; i++) step();
    tests_run++;
    if (issued_addr.size() < 3) begin
      fails++;
      $display("[TB] FAIL seq_count got %0d requests exp >=3", issued_addr.size());
    end else begin
      tests_run++;
      if (issued_addr[0] !== 32'h0 || issued_addr[1] !== 32'h4 || issued_addr[2] !== 32'h8) begin
        fails++;
        $display("[TB] FAIL seq_addr got %h %h %h exp 0 4 8",
                 issued_addr[0], issued_addr[1], issued_addr[2]);
      end
      tests_run++;
      if (issued_cyc[0] != release_cyc || issued_cyc[1] != release_cyc + 1 ||
          issued_cyc[2] != release_cyc + 2) begin
        fails++;
        $display("[TB] FAIL seq_timing got offsets %0d %0d %0d exp 0 1 2", issued_cyc[0] - release_cyc,
                 issued_cyc[1] - release_cyc, issued_cyc[2] - release_cyc);
      end
    end
    tests_run++;
    if (first_valid_cyc - release_cyc != 2) begin
      fails++;
      $display("[TB] FAIL first_valid got offset %0d exp 2", first_valid_cyc - release_cyc);
    end
    p0 = pops;
    for (int i = 0; i < 8; i++) step();
    tests_run++;
    if (pops - p0 != 8) begin
      fails++;
      $display("[TB] FAIL throughput got %0d pops exp 8", pops - p0);
    end
  endtask

  task automatic test_backpressure();
    int g0;
    lat_min = 1; lat_max = 1; gnt_pct = 100;
    do_reset(2);
    for (int i = 0; i < 4; i++) step();
    ready_drv = 1'b0;
    g0 = grants;
    for (int i = 0; i < 5; i++) step();
    tests_run++;
    if (grants - g0 > DEPTH) begin
      fails++;
      $display("[TB] FAIL bp_grants got %0d exp <=%0d", grants - g0, DEPTH);
    end
    tests_run++;
    if (imem_req_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL bp_req got %b exp 0", imem_req_o);
    end
    ready_drv = 1'b1;
    for (int i = 0; i < 10; i++) step();
    for (int i = 0; i < popped_pc.size(); i++) begin
      tests_run++;
      if (popped_pc[i] !== RESET_PC + 32'(4 * i)) begin
        fails++;
        $display("[TB] FAIL bp_seq idx=%0d got %h exp %h", i, popped_pc[i], RESET_PC + 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect();
    int  n;
    bit  seen;
    lat_min = 3; lat_max = 3; gnt_pct = 100;
    do_reset(2);
    for (int i = 0; i < 10 && minfl.size() < 2; i++) step();
    n = issued_addr.size();
    redirect_drv = 1'b1; target_drv = 32'h0000_0103;
    step();
    redirect_drv = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (instr_valid_o === 1'b1) seen = 1'b1;
    end
    tests_run++;
    if (!seen || pc_o !== 32'h0000_0100) begin
      fails++;
      $display("[TB] FAIL redirect_pc got valid=%b pc=%h exp 1 00000100", seen, pc_o);
    end
    tests_run++;
    if (issued_addr.size() <= n || issued_addr[n] !== 32'h0000_0100) begin
      fails++;
      $display("[TB] FAIL redirect_addr got %0d issued, first %h exp 00000100",
               issued_addr.size() - n, issued_addr.size() > n ? issued_addr[n] : 32'hx);
    end
  endtask

  task automatic test_redirect_rvalid();
    bit seen;
    lat_min = 2; lat_max = 2; gnt_pct = 100;
    do_reset(2);
    for (int i = 0; i < 10 && !(memq.size() > 0 && memq[0].due <= cyc); i++) step();
    redirect_drv = 1'b1; target_drv = 32'h0000_2000;
    step();
    redirect_drv = 1'b0;
    step();
    tests_run++;
    if (instr_valid_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL redir_rvalid_valid got %b exp 0", instr_valid_o);
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (instr_valid_o === 1'b1) seen = 1'b1;
    end
    tests_run++;
    if (!seen || pc_o !== 32'h0000_2000) begin
      fails++;
      $display("[TB] FAIL redir_rvalid_pc got valid=%b pc=%h exp 1 00002000", seen, pc_o);
    end
  endtask

  task automatic test_grant_stall();
    lat_min = 1; lat_max = 1; gnt_pct = 0;
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      step();
      tests_run++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC) begin
        fails++;
        $display("[TB] FAIL stall_addr i=%0d got req=%b addr=%h exp 1 %h", i, imem_req_o, imem_addr_o, RESET_PC);
      end
    end
    gnt_pct = 100;
    step();
    step();
    tests_run++;
    if (imem_addr_o !== RESET_PC + 32'd4) begin
      fails++;
      $display("[TB] FAIL stall_advance got %h exp %h", imem_addr_o, RESET_PC + 32'd4);
    end
  endtask

  task automatic test_wrap_and_midreset();
    int n;
    lat_min = 1; lat_max = 1; gnt_pct = 100;
    do_reset(2);
    for (int i = 0; i < 3; i++) step();
    n = issued_addr.size();
    redirect_drv = 1'b1; target_drv = 32'hFFFF_FFFE;
    step();
    redirect_drv = 1'b0;
    for (int i = 0; i < 4; i++) step();
    tests_run++;
    if (issued_addr.size() < n + 2 || issued_addr[n] !== 32'hFFFF_FFFC || issued_addr[n+1] !== 32'h0) begin
      fails++;
      $display("[TB] FAIL wrap got %0d issued after redirect exp FFFFFFFC then 00000000", issued_addr.size() - n);
    end
    lat_min = 3; lat_max = 3;
    do_reset(2);
    step();
    tests_run++;
    if (memq.size() != 1) begin
      fails++;
      $display("[TB] FAIL midreset_setup got %0d outstanding exp 1", memq.size());
    end
    do_reset(1);
    step();
    tests_run++;
    if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC) begin
      fails++;
      $display("[TB] FAIL midreset got valid=%b req=%b addr=%h exp 0 1 %h",
               instr_valid_o, imem_req_o, imem_addr_o, RESET_PC);
    end
    for (int i = 0; i < 8; i++) step();
  endtask

  task automatic test_random();
    lat_min = 1; lat_max = 4; gnt_pct = 70;
    do_reset(2);
    for (int i = 0; i < 800; i++) begin
      ready_drv    = ($urandom_range(0, 99) < 75);
      redirect_drv = (mbuf.size() > 0) && ($urandom_range(0, 24) == 0);
      target_drv   = $urandom;
      step();
    end
    redirect_drv = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_redirect_rvalid();
    test_grant_stall();
    test_wrap_and_midreset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] timeout");
  end

endmodule
